perf_stat_reader: RTL and testbench

- Reader end of the CPU performance counter block: takes the four 32-bit statistics (total cycles, jumps, taken branches, load-use stalls) and streams them out as a framed byte sequence.
- The output uses a valid/ready handshake and feeds the debug UART/display path.
- On each request the block takes an atomic snapshot of all four counters, so the frame is coherent even while the counters keep running.

---
 rtl/perf_stat_reader_pkg.sv | 23 ++
 rtl/perf_stat_reader_if.sv | 10 +
 rtl/perf_stat_reader_stat_byte_mux.sv | 26 ++
 rtl/perf_stat_reader.sv | 119 +++++++++++
 tb/tb_perf_stat_reader.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/perf_stat_reader_pkg.sv
// Shared types and constants for the performance-statistics frame reader.
package perf_stat_reader_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    DATA,
    CHK
  } state_e;

  localparam logic [7:0] HDR_BYTE_DEFAULT = 8'hA5;

  localparam int N_CNT         = 4;
  localparam int PAYLOAD_BYTES = 16;
  localparam int FRAME_BYTES   = 18;

  // Position of each counter in the snapshot and in the frame payload.
  localparam int IDX_TOTAL   = 0;
  localparam int IDX_J       = 1;
  localparam int IDX_JS      = 2;
  localparam int IDX_LOADUSE = 3;

endpackage

// File: rtl/perf_stat_reader_if.sv
// Byte-stream handshake between the statistics reader and its sink.
interface perf_stat_reader_if;
  logic       out_valid;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_last;

  modport master (output out_valid, output out_data, output out_last, input in_ready);
  modport slave  (input out_valid, input out_data, input out_last, output in_ready);
endinterface

// File: rtl/perf_stat_reader_stat_byte_mux.sv
// Selects one payload byte out of the counter snapshot.
// Byte 0 is the MSB of the first counter; bytes run big-endian per counter.
module stat_byte_mux
  import perf_stat_reader_pkg::*;
#(
  parameter  int CNT_W = 32,
  localparam int BPC   = CNT_W / 8,
  localparam int NB    = N_CNT * BPC,
  localparam int IDX_W = $clog2(NB)
) (
  input  logic [N_CNT-1:0][CNT_W-1:0] snap,
  input  logic [IDX_W-1:0]            idx,
  output logic [7:0]                  sel_byte
);

  logic [7:0] bytes [NB];

  for (genvar c = 0; c < N_CNT; c++) begin : g_cnt
    for (genvar b = 0; b < BPC; b++) begin : g_byte
      assign bytes[c*BPC + b] = snap[c][CNT_W-1-8*b -: 8];
    end
  end

  assign sel_byte = bytes[idx];

endmodule

// File: rtl/perf_stat_reader.sv
// Snapshots the four performance counters on request and streams them as
// an 18-byte frame: header, big-endian payload, XOR checksum of the payload.
module perf_stat_reader
  import perf_stat_reader_pkg::*;
#(
  parameter int         CNT_W    = 32,
  parameter logic [7:0] HDR_BYTE = HDR_BYTE_DEFAULT
) (
  input  logic             in_CLK,
  input  logic             in_RST,
  input  logic [CNT_W-1:0] in_total,
  input  logic [CNT_W-1:0] in_J,
  input  logic [CNT_W-1:0] in_JS,
  input  logic [CNT_W-1:0] in_loaduse,
  input  logic             in_req,
  perf_stat_reader_if.master bus,
  output logic             out_busy,
  output logic             out_ovr
);

  localparam int               NB       = N_CNT * (CNT_W / 8);
  localparam int               IDX_W    = $clog2(NB);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NB - 1);

  state_e                      state, state_nxt;
  logic [N_CNT-1:0][CNT_W-1:0] snap;
  logic [IDX_W-1:0]            idx;
  logic [7:0]                  chk;
  logic [7:0]                  cur_byte;
  logic                        xfer;

  stat_byte_mux #(.CNT_W(CNT_W)) u_mux (
    .snap     (snap),
    .idx      (idx),
    .sel_byte (cur_byte)
  );

  // Every non-idle state presents a byte, so a transfer is just ready outside IDLE.
  assign xfer = (state != IDLE) && bus.in_ready;

  // Next-state and output decode; outputs depend only on registered state.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latches).
    state_nxt     = state;
    bus.out_valid = 1'b0;
    bus.out_data  = '0;
    bus.out_last  = 1'b0;
    out_busy      = 1'b0;
    case (state)
      IDLE: begin
        if (in_req) state_nxt = HDR;
      end
      HDR: begin
        bus.out_valid = 1'b1;
        bus.out_data  = HDR_BYTE;
        out_busy      = 1'b1;
        if (bus.in_ready) state_nxt = DATA;
      end
      DATA: begin
        bus.out_valid = 1'b1;
        bus.out_data  = cur_byte;
        out_busy      = 1'b1;
        if (bus.in_ready && idx == IDX_LAST) state_nxt = CHK;
      end
      CHK: begin
        bus.out_valid = 1'b1;
        bus.out_data  = chk;
        bus.out_last  = 1'b1;
        out_busy      = 1'b1;
        if (bus.in_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register; reset aborts any frame in flight.
  always_ff @(posedge in_CLK or negedge in_RST) begin
    // NOTE: sequential state uses <= so every register samples pre-edge values.
    if (!in_RST) state <= IDLE;
    else         state <= state_nxt;
  end

  // Snapshot, byte index, running checksum and sticky overrun flag.
  always_ff @(posedge in_CLK or negedge in_RST) begin
    if (!in_RST) begin
      // NOTE: the snapshot is a small register bank, not a RAM, so it is reset with everything else.
      snap    <= '0;
      idx     <= '0;
      chk     <= '0;
      out_ovr <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_req) begin
            snap[IDX_TOTAL]   <= in_total;
            snap[IDX_J]       <= in_J;
            snap[IDX_JS]      <= in_JS;
            snap[IDX_LOADUSE] <= in_loaduse;
            chk               <= '0;
            out_ovr           <= 1'b0;
          end
        end
        HDR: begin
          if (xfer) idx <= '0;
        end
        DATA: begin
          if (xfer) begin
            chk <= chk ^ cur_byte;
            idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
      // A request seen in any state other than IDLE, including the last CHK edge, is an overrun.
      if (in_req && state != IDLE) out_ovr <= 1'b1;
    end
  end

endmodule

// File: tb/tb_perf_stat_reader.sv
// Scoreboard bench for perf_stat_reader: stimulus pushes the expected frame
// bytes, an independent monitor pops and compares on every transfer.
module tb_perf_stat_reader;
  import perf_stat_reader_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] total = '0, cj = '0, cjs = '0, clu = '0;
  logic        req = 1'b0;
  logic        busy, ovr;

  perf_stat_reader_if bus ();

  perf_stat_reader #(.CNT_W(32), .HDR_BYTE(8'hA5)) dut (
    .in_CLK     (clk),
    .in_RST     (rst_n),
    .in_total   (total),
    .in_J       (cj),
    .in_JS      (cjs),
    .in_loaduse (clu),
    .in_req     (req),
    .bus        (bus),
    .out_busy   (busy),
    .out_ovr    (ovr)
  );

  always #5 clk = ~clk;

  int         errors = 0;
  int         checks = 0;
  logic [8:0] exp_q [$];   // {last, data}
  int         ready_mode = 0;
  bit         exp_ovr = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference frame: header, four counters big-endian, XOR of payload bytes.
  task automatic push_frame(input logic [31:0] t, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] c);
    logic [31:0] v [4];
    logic [7:0]  x, ck;
    v  = '{t, a, b, c};
    ck = 8'h00;
    exp_q.push_back({1'b0, 8'hA5});
    for (int i = 0; i < N_CNT; i++)
      for (int k = 3; k >= 0; k--) begin
        x  = 8'(v[i] >> (8 * k));
        ck = ck ^ x;
        exp_q.push_back({1'b0, x});
      end
    exp_q.push_back({1'b1, ck});
  endtask

  // Called at posedge+1 with the DUT idle; issues a one-cycle request.
  task automatic do_req(input logic [31:0] t, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] c);
    check("ovr_before_req", 32'(ovr), 32'(exp_ovr));
    total = t; cj = a; cjs = b; clu = c;
    req = 1'b1;
    @(posedge clk); #1;
    req = 1'b0;
    push_frame(t, a, b, c);
    exp_ovr = 1'b0;
    check("busy_after_req", 32'(busy), 32'd1);
    check("ovr_cleared", 32'(ovr), 32'd0);
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy) begin
      if (n == 2000) begin
        checks++; errors++;
        $display("FAIL idle_timeout: still busy after %0d cycles", n);
        break;
      end
      @(posedge clk); #1;
      n++;
    end
  endtask

  // Sink ready pattern generator.
  int ph = 0;
  initial begin
    bus.in_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0: bus.in_ready = 1'b1;
        1: begin bus.in_ready = (ph == 0); ph = (ph + 1) % 3; end
        default: bus.in_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: compares each transferred byte and checks hold-while-stalled.
  logic       pv = 1'b0;
  logic [8:0] pd = '0;
  logic [8:0] e;
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) pv = 1'b0;
      else begin
        if (pv) check("hold_stable", {23'd0, bus.out_valid, bus.out_last, bus.out_data}, {23'd0, 1'b1, pd});
        if (bus.out_valid && bus.in_ready) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_byte: got %0h with no frame expected", bus.out_data);
          end else begin
            e = exp_q.pop_front();
            check("frame_byte", {23'd0, bus.out_last, bus.out_data}, {23'd0, e});
          end
          pv = 1'b0;
        end else if (bus.out_valid) begin
          pv = 1'b1;
          pd = {bus.out_last, bus.out_data};
        end else pv = 1'b0;
      end
    end
  end

  int n, guard;
  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 32'(bus.out_valid), 0);
    check("rst_data",  32'(bus.out_data), 0);
    check("rst_last",  32'(bus.out_last), 0);
    check("rst_busy",  32'(busy), 0);
    check("rst_ovr",   32'(ovr), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic frame, back-to-back
    ready_mode = 0;
    do_req(32'h10, 32'h2, 32'h1, 32'h3);
    wait_idle(n);
    check("frame_cycles", n, FRAME_BYTES);

    // Same frame with 1,0,0 ready pattern
    ready_mode = 1;
    do_req(32'h10, 32'h2, 32'h1, 32'h3);
    wait_idle(n);

    // Counters change right after the snapshot
    ready_mode = 0;
    do_req(32'h10, 32'h2, 32'h1, 32'h3);
    total = '1; cj = '1; cjs = '1; clu = '1;
    wait_idle(n);

    // Request mid-payload sets overrun, frame unaffected
    do_req(32'h10, 32'h2, 32'h1, 32'h3);
    repeat (6) @(posedge clk);
    #1;
    req = 1'b1;
    @(posedge clk); #1;
    req = 1'b0;
    exp_ovr = 1'b1;
    check("ovr_mid_frame", 32'(ovr), 1);
    wait_idle(n);
    check("ovr_sticky", 32'(ovr), 1);
    do_req(32'hDEADBEEF, 32'h01234567, 32'h89ABCDEF, 32'h0);
    wait_idle(n);

    // Request on the CHK transfer edge: overrun, no new frame
    do_req(32'h11, 32'h22, 32'h33, 32'h44);
    guard = 0;
    while (!bus.out_last && guard < 100) begin @(posedge clk); #1; guard++; end
    check("reach_chk", 32'(bus.out_last), 1);
    req = 1'b1;
    @(posedge clk); #1;
    req = 1'b0;
    exp_ovr = 1'b1;
    check("chk_edge_busy", 32'(busy), 0);
    check("chk_edge_ovr", 32'(ovr), 1);
    check("chk_edge_q", exp_q.size(), 0);

    // Asynchronous reset mid-DATA
    do_req(32'hCAFEF00D, 32'h5, 32'h6, 32'h7);
    repeat (6) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(bus.out_valid), 0);
    check("async_rst_busy", 32'(busy), 0);
    check("async_rst_ovr", 32'(ovr), 0);
    exp_q.delete();
    exp_ovr = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_req(32'h10, 32'h2, 32'h1, 32'h3);
    wait_idle(n);

    // All ones: payload FF, checksum 00
    ready_mode = 2;
    do_req('1, '1, '1, '1);
    wait_idle(n);

    // Randomized frames with scrambled counters and occasional overruns
    for (int f = 0; f < 20; f++) begin
      ready_mode = int'($urandom_range(0, 2));
      do_req($urandom, $urandom, $urandom, $urandom);
      guard = 0;
      while (busy && guard < 2000) begin
        total = $urandom; cj = $urandom; cjs = $urandom; clu = $urandom;
        if (!req && exp_q.size() > 2 && $urandom_range(0, 19) == 0) begin
          req = 1'b1;
          exp_ovr = 1'b1;
        end else req = 1'b0;
        @(posedge clk); #1;
        guard++;
      end
      req = 1'b0;
      wait_idle(n);
    end

    check("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
